transport_ctrl: RTL and testbench

- Central mode sequencer for the voice recorder.
- Turns debounced button levels into the `play` and `record` enables, the speed controls `fast`, `slow` and `slowmethod`, and a latched recording length.
- Sits between the debounce instances and the adc/dac/sram blocks. It replaces direct wiring of button levels to `play`/`record`.
- Ends recording and playback automatically: recording stops at end of memory, playback stops at the end of the recorded data.

---
 rtl/transport_ctrl.sv | 142 ++++++++++++++
 tb/tb_transport_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/transport_ctrl.sv
// Transport mode sequencer for the voice recorder: turns debounced button
// levels into record/play enables, speed controls and a latched recording length.
module transport_ctrl #(
  parameter int unsigned           ADDR_W   = 18,
  parameter logic [ADDR_W-1:0]     MAX_ADDR = '1,
  parameter int unsigned           NSPEED   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_play,
  input  logic              btn_record,
  input  logic              btn_stop,
  input  logic              btn_speed,
  input  logic              btn_interp,
  input  logic [ADDR_W-1:0] adc_addr,
  input  logic [ADDR_W-1:0] dac_addr,
  output logic              play,
  output logic              record,
  output logic [3:0]        fast,
  output logic [3:0]        slow,
  output logic              slowmethod,
  output logic [ADDR_W-1:0] rec_end,
  output logic [1:0]        state,
  output logic              done
);

  localparam int unsigned IDX_W = (NSPEED > 1) ? $clog2(NSPEED) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2,
    S_PAUSE  = 2'd3
  } state_t;

  state_t              st, nxt_st;
  logic [4:0]          btn, btn_q, edges;
  logic                play_e, rec_e, stop_e, speed_e, interp_e;
  logic [IDX_W-1:0]    idx, nxt_idx;
  logic [ADDR_W-1:0]   nxt_rec_end;
  logic                nxt_done;
  logic [3:0]          nxt_fast, nxt_slow;

  // Speed table entry as {fast, slow}; never both factors above 1.
  function automatic logic [7:0] speed_entry(input logic [IDX_W-1:0] i);
    logic [7:0] e;
    case (int'(i))
      0:       e = {4'd1, 4'd1};
      1:       e = {4'd2, 4'd1};
      2:       e = {4'd4, 4'd1};
      3:       e = {4'd8, 4'd1};
      4:       e = {4'd1, 4'd2};
      5:       e = {4'd1, 4'd4};
      6:       e = {4'd1, 4'd8};
      default: e = {4'd1, 4'd1};
    endcase
    return e;
  endfunction

  assign btn      = {btn_interp, btn_speed, btn_stop, btn_record, btn_play};
  assign edges    = btn & ~btn_q;
  assign play_e   = edges[0];
  assign rec_e    = edges[1];
  assign stop_e   = edges[2];
  assign speed_e  = edges[3];
  assign interp_e = edges[4];

  always_comb begin
    nxt_st      = st;
    nxt_rec_end = rec_end;
    nxt_done    = 1'b0;
    case (st)
      S_IDLE: begin
        if (stop_e)                          nxt_st = S_IDLE;
        else if (rec_e)                      nxt_st = S_RECORD;
        else if (play_e && rec_end != '0)    nxt_st = S_PLAY;
      end
      S_RECORD: begin
        if (stop_e || rec_e) begin
          nxt_st      = S_IDLE;
          nxt_rec_end = adc_addr;
        end else if (adc_addr == MAX_ADDR) begin
          nxt_st      = S_IDLE;
          nxt_rec_end = MAX_ADDR;
          nxt_done    = 1'b1;
        end
      end
      S_PLAY: begin
        if (stop_e)                  nxt_st = S_IDLE;
        else if (rec_e)              nxt_st = S_RECORD;
        else if (play_e)             nxt_st = S_PAUSE;
        else if (dac_addr >= rec_end) begin
          nxt_st   = S_IDLE;
          nxt_done = 1'b1;
        end
      end
      default: begin
        if (stop_e)        nxt_st = S_IDLE;
        else if (rec_e)    nxt_st = S_RECORD;
        else if (play_e)   nxt_st = S_PLAY;
      end
    endcase
  end

  // Speed advances only while no transfer is running.
  always_comb begin
    nxt_idx = idx;
    if (speed_e && (st == S_IDLE || st == S_PAUSE))
      nxt_idx = (idx == IDX_W'(NSPEED - 1)) ? '0 : idx + 1'b1;
    {nxt_fast, nxt_slow} = speed_entry(nxt_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q      <= '1;
      st         <= S_IDLE;
      play       <= 1'b0;
      record     <= 1'b0;
      idx        <= '0;
      fast       <= 4'd1;
      slow       <= 4'd1;
      slowmethod <= 1'b0;
      rec_end    <= '0;
      done       <= 1'b0;
    end else begin
      btn_q      <= btn;
      st         <= nxt_st;
      play       <= (nxt_st == S_PLAY);
      record     <= (nxt_st == S_RECORD);
      idx        <= nxt_idx;
      fast       <= nxt_fast;
      slow       <= nxt_slow;
      rec_end    <= nxt_rec_end;
      done       <= nxt_done;
      if (interp_e)
        slowmethod <= ~slowmethod;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_transport_ctrl.sv
// Scoreboard bench for transport_ctrl: the driver runs a behavioural model and
// queues expected outputs; a monitor compares them one cycle later.
module tb_transport_ctrl;

  localparam int unsigned ADDR_W = 18;
  localparam logic [ADDR_W-1:0] MAXA = 18'h3FFFF;
  localparam logic [4:0] P_PLAY = 5'b00001, P_REC = 5'b00010, P_STOP = 5'b00100,
                         P_SPD  = 5'b01000, P_INT = 5'b10000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [4:0]        btns = '0;
  logic [ADDR_W-1:0] adc_addr = '0, dac_addr = '0;
  logic              play, record, slowmethod, done;
  logic [3:0]        fast, slow;
  logic [ADDR_W-1:0] rec_end;
  logic [1:0]        state;

  transport_ctrl #(.ADDR_W(ADDR_W), .NSPEED(7)) dut (
    .clk(clk), .reset(reset),
    .btn_play(btns[0]), .btn_record(btns[1]), .btn_stop(btns[2]),
    .btn_speed(btns[3]), .btn_interp(btns[4]),
    .adc_addr(adc_addr), .dac_addr(dac_addr),
    .play(play), .record(record), .fast(fast), .slow(slow),
    .slowmethod(slowmethod), .rec_end(rec_end), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: 0 idle, 1 record, 2 play, 3 pause.
  int          m_state = 0;
  int          m_idx = 0;
  bit          m_sm = 1'b0;
  bit          m_done = 1'b0;
  int unsigned m_recend = 0;
  logic [4:0]  m_prev = '1;
  int          fast_tab [7] = '{1, 2, 4, 8, 1, 1, 1};
  int          slow_tab [7] = '{1, 1, 1, 1, 2, 4, 8};

  logic [31:0] exp_q [$];
  int          nchecks = 0, npass = 0;

  function automatic logic [31:0] pack_exp();
    logic [31:0] v;
    v = {2'(m_state), (m_state == 2), (m_state == 1), 4'(fast_tab[m_idx]),
         4'(slow_tab[m_idx]), m_sm, 18'(m_recend), m_done};
    return v;
  endfunction

  task automatic step(input logic rst, input logic [4:0] b,
                      input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] d);
    logic [4:0] e;
    @(negedge clk);
    reset = rst; btns = b; adc_addr = a; dac_addr = d;
    m_done = 1'b0;
    if (rst) begin
      m_state = 0; m_idx = 0; m_sm = 1'b0; m_recend = 0; m_prev = '1;
    end else begin
      e = b & ~m_prev;
      m_prev = b;
      if (e[3] && (m_state == 0 || m_state == 3)) m_idx = (m_idx + 1) % 7;
      if (e[4]) m_sm = ~m_sm;
      if (m_state == 0) begin
        if (e[2]) m_state = 0;
        else if (e[1]) m_state = 1;
        else if (e[0] && m_recend != 0) m_state = 2;
      end else if (m_state == 1) begin
        if (e[2] || e[1]) begin m_state = 0; m_recend = a; end
        else if (a == MAXA) begin m_state = 0; m_recend = MAXA; m_done = 1'b1; end
      end else if (m_state == 2) begin
        if (e[2]) m_state = 0;
        else if (e[1]) m_state = 1;
        else if (e[0]) m_state = 3;
        else if (d >= m_recend) begin m_state = 0; m_done = 1'b1; end
      end else begin
        if (e[2]) m_state = 0;
        else if (e[1]) m_state = 1;
        else if (e[0]) m_state = 2;
      end
    end
    exp_q.push_back(pack_exp());
  endtask

  task automatic press(input logic [4:0] b, input logic [ADDR_W-1:0] a,
                       input logic [ADDR_W-1:0] d);
    step(1'b0, b, a, d);
    step(1'b0, '0, a, d);
  endtask

  always @(posedge clk) begin
    logic [31:0] act, exp_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act = {state, play, record, fast, slow, slowmethod, rec_end, done};
      nchecks++;
      if (act === exp_v) npass++;
      else $display("FAIL outputs @%0t: got st=%0d pl=%0b rc=%0b f=%0d s=%0d sm=%0b re=%0d dn=%0b, expected st=%0d pl=%0b rc=%0b f=%0d s=%0d sm=%0b re=%0d dn=%0b",
                    $time, act[31:30], act[29], act[28], act[27:24], act[23:20], act[19], act[18:1], act[0],
                    exp_v[31:30], exp_v[29], exp_v[28], exp_v[27:24], exp_v[23:20], exp_v[19], exp_v[18:1], exp_v[0]);
    end
  end

  initial begin
    logic [4:0] cur;
    logic [ADDR_W-1:0] a, d;
    step(1'b1, '0, '0, '0);
    step(1'b1, '0, '0, '0);
    // Play with nothing recorded is ignored.
    press(P_PLAY, '0, '0);
    // Record, stop at 1000.
    press(P_REC, 18'd10, '0);
    step(1'b0, '0, 18'd1000, '0);
    press(P_STOP, 18'd1000, '0);
    // Play until dac reaches rec_end.
    press(P_PLAY, '0, '0);
    for (int i = 990; i <= 1003; i++) step(1'b0, '0, '0, 18'(i));
    // Play, pause, play, stop.
    press(P_PLAY, '0, '0);
    press(P_PLAY, '0, '0);
    press(P_PLAY, '0, '0);
    press(P_STOP, '0, '0);
    // Record into end of memory.
    press(P_REC, MAXA - 18'd8, '0);
    for (int i = 5; i >= 0; i--) step(1'b0, '0, MAXA - 18'(i), '0);
    step(1'b0, '0, MAXA, '0);
    // Speed cycling in idle, ignored during play; interp toggles.
    for (int i = 0; i < 8; i++) press(P_SPD, '0, '0);
    press(P_PLAY, '0, '0);
    press(P_SPD, '0, '0);
    press(P_INT, '0, '0);
    press(P_INT, '0, '0);
    press(P_SPD | P_INT, '0, '0);
    press(P_STOP, '0, '0);
    press(P_SPD | P_INT, '0, '0);
    // Stop and record together in idle.
    press(P_STOP | P_REC, '0, '0);
    // Reset while playing at fast = 4.
    press(P_PLAY, '0, '0);
    step(1'b1, '0, '0, '0);
    step(1'b0, '0, '0, '0);
    // Randomized phase.
    cur = '0;
    for (int n = 0; n < 4000; n++) begin
      for (int k = 0; k < 5; k++)
        if ($urandom_range(0, 5) == 0) cur[k] = ~cur[k];
      a = ($urandom_range(0, 40) == 0) ? MAXA : 18'($urandom_range(0, 30000));
      d = 18'($urandom_range(0, 30000));
      step(($urandom_range(0, 600) == 0) ? 1'b1 : 1'b0, cur, a, d);
    end
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      nchecks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
